// File: rtl/spi_alu_slave_cfg.sv
`timescale 1ns/1ps
// spi_alu_slave_cfg
// SPI slave that receives an opcode header and two WIDTH-bit operands,
// runs one ALU operation and shifts back {result, Z, N, C, V}.
// All SPI pins are synchronised into the clock domain and edges of the
// synchronised SCLK drive the protocol FSM; CPOL/CPHA select which edge
// samples MOSI and which edge advances MISO.
module spi_alu_slave_cfg #(
   parameter int WIDTH       = 32,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sclk,
   input  logic             nss,
   input  logic             mosi,
   output logic             miso,
   output logic [WIDTH-1:0] result_q,
   output logic [3:0]       flags_q,
   output logic             busy,
   output logic             done,
   output logic             frame_err
);

   localparam int SW  = $clog2(WIDTH);
   localparam int TXW = WIDTH + 4;
   localparam int CW  = $clog2(WIDTH + 4);
   localparam logic CPOL_BIT = (CPOL != 0);
   localparam logic CPHA_BIT = (CPHA != 0);

   localparam logic [CW-1:0] HDR_LAST  = CW'(7);
   localparam logic [CW-1:0] WORD_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] TX_LAST   = CW'(WIDTH + 3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_OP,
      S_RX_A,
      S_RX_B,
      S_EXEC,
      S_TX,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   w_abort;

   // synchronisers and edge detection
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_nss_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_d;
   logic w_sclk, w_nss, w_mosi;
   logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;

   // receive / transmit datapath
   logic [CW-1:0]    r_bit_cnt;
   logic [WIDTH-2:0] r_rx_shift;
   logic [WIDTH-1:0] w_rx_word;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [TXW-1:0]   r_tx_shift;
   logic             r_first_shift;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic             r_done;
   logic             r_frame_err;
   logic             w_rx_active;

   // ALU
   logic [SW-1:0]    w_amt;
   logic [SW:0]      w_rot_inv;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_shl_ext;
   logic [WIDTH:0]   w_shr_ext;
   logic [WIDTH:0]   w_sra_ext;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_c;
   logic             w_alu_v;
   logic [3:0]       w_alu_flags;

   // Synchronisers reset to the idle bus levels (nss high, sclk at CPOL) so
   // releasing reset never looks like a frame start or a clock edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sclk_sync <= {SYNC_STAGES{CPOL_BIT}};
         r_nss_sync  <= {SYNC_STAGES{1'b1}};
         r_mosi_sync <= '0;
         r_sclk_d    <= CPOL_BIT;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], nss};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      end
   end

   assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
   assign w_nss    = r_nss_sync[SYNC_STAGES-1];
   assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
   assign w_rise   = w_sclk & ~r_sclk_d;
   assign w_fall   = ~w_sclk & r_sclk_d;
   assign w_lead   = CPOL_BIT ? w_fall : w_rise;
   assign w_trail  = CPOL_BIT ? w_rise : w_fall;
   assign w_sample = CPHA_BIT ? w_trail : w_lead;
   assign w_shift  = CPHA_BIT ? w_lead : w_trail;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a deselect mid-frame outranks any bit edge in the same clock.
   always_comb begin
      w_state_next = r_state;
      w_abort      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_nss) begin
               w_state_next = S_RX_OP;
            end
         end
         S_RX_OP: begin
            if (w_nss) begin
               w_state_next = S_IDLE;
               w_abort      = 1'b1;
            end else if (w_sample && (r_bit_cnt == HDR_LAST)) begin
               w_state_next = S_RX_A;
            end
         end
         S_RX_A: begin
            if (w_nss) begin
               w_state_next = S_IDLE;
               w_abort      = 1'b1;
            end else if (w_sample && (r_bit_cnt == WORD_LAST)) begin
               w_state_next = S_RX_B;
            end
         end
         S_RX_B: begin
            if (w_nss) begin
               w_state_next = S_IDLE;
               w_abort      = 1'b1;
            end else if (w_sample && (r_bit_cnt == WORD_LAST)) begin
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_next = S_TX;
         end
         S_TX: begin
            if (w_nss) begin
               w_state_next = S_IDLE;
               w_abort      = 1'b1;
            end else if (w_sample && (r_bit_cnt == TX_LAST)) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (w_nss) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign w_rx_active = (r_state == S_RX_OP) || (r_state == S_RX_A) || (r_state == S_RX_B);
   assign w_rx_word   = {r_rx_shift, w_mosi};

   // Bit counter and receive shifter; each field is latched on the edge that completes it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_bit_cnt  <= '0;
         r_rx_shift <= '0;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
      end else begin
         if (w_state_next != r_state) begin
            r_bit_cnt <= '0;
         end else if (w_sample && (w_rx_active || (r_state == S_TX))) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_sample && w_rx_active) begin
            r_rx_shift <= w_rx_word[WIDTH-2:0];
         end
         if ((r_state == S_RX_OP) && (w_state_next == S_RX_A)) begin
            r_op <= w_rx_word[7:4];
         end
         if ((r_state == S_RX_A) && (w_state_next == S_RX_B)) begin
            r_a <= w_rx_word;
         end
         if ((r_state == S_RX_B) && (w_state_next == S_EXEC)) begin
            r_b <= w_rx_word;
         end
      end
   end

   // Shift/rotate helpers: the extra bit of each widened shift catches the
   // last bit shifted out, which is exactly the carry for SHL/SHR/SRA.
   assign w_amt     = r_b[SW-1:0];
   assign w_rot_inv = (SW+1)'(WIDTH) - {1'b0, w_amt};
   assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
   assign w_shl_ext = {1'b0, r_a} << w_amt;
   assign w_shr_ext = {r_a, 1'b0} >> w_amt;
   assign w_sra_ext = $signed({r_a, 1'b0}) >>> w_amt;

   // ALU result and carry/overflow; undefined opcodes yield zero.
   always_comb begin
      w_alu_res = '0;
      w_alu_c   = 1'b0;
      w_alu_v   = 1'b0;
      case (r_op)
         4'd0: begin
            w_alu_res = w_sum[WIDTH-1:0];
            w_alu_c   = w_sum[WIDTH];
            w_alu_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         4'd1: begin
            w_alu_res = w_diff[WIDTH-1:0];
            w_alu_c   = w_diff[WIDTH];
            w_alu_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
         end
         4'd2: w_alu_res = r_a & r_b;
         4'd3: w_alu_res = r_a | r_b;
         4'd4: w_alu_res = r_a ^ r_b;
         4'd5: w_alu_res = ~r_a;
         4'd6: begin
            w_alu_res = w_shl_ext[WIDTH-1:0];
            w_alu_c   = w_shl_ext[WIDTH];
         end
         4'd7: begin
            w_alu_res = w_shr_ext[WIDTH:1];
            w_alu_c   = w_shr_ext[0];
         end
         4'd8: begin
            w_alu_res = w_sra_ext[WIDTH:1];
            w_alu_c   = w_sra_ext[0];
         end
         4'd9:  w_alu_res = (r_a << w_amt) | (r_a >> w_rot_inv);
         4'd10: w_alu_res = (r_a >> w_amt) | (r_a << w_rot_inv);
         default: w_alu_res = '0;
      endcase
   end

   assign w_alu_flags = {(w_alu_res == '0), w_alu_res[WIDTH-1], w_alu_c, w_alu_v};

   // Result capture, transmit shifter and the CPU-side status pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_result      <= '0;
         r_flags       <= '0;
         r_tx_shift    <= '0;
         r_first_shift <= 1'b0;
         r_done        <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_done      <= (r_state == S_EXEC);
         r_frame_err <= w_abort;
         if (r_state == S_EXEC) begin
            r_result      <= w_alu_res;
            r_flags       <= w_alu_flags;
            r_tx_shift    <= {w_alu_res, w_alu_flags};
            r_first_shift <= 1'b1;
         end else if ((r_state == S_TX) && w_shift) begin
            // The MSB is already on miso when TX starts, so the first shift edge only arms shifting.
            if (r_first_shift) begin
               r_first_shift <= 1'b0;
            end else begin
               r_tx_shift <= {r_tx_shift[TXW-2:0], 1'b0};
            end
         end
      end
   end

   assign miso      = (r_state == S_TX) ? r_tx_shift[TXW-1] : 1'b0;
   assign result_q  = r_result;
   assign flags_q   = r_flags;
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign frame_err = r_frame_err;

endmodule
